// File: rtl/spi_chip_pkg.sv
// rtl/spi_chip_pkg.sv - opcodes and FSM state type for the SPI chip responder
package spi_chip_pkg;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        W_ADDR,
        W_DATA,
        R_ADDR,
        R_COUNT,
        R_DATA,
        DROP
    } resp_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - 2-FF synchronizers for spi_clk/mosi with rise/fall pulses
module spi_edge_sync (
    input  logic clk,
    input  logic rstn,
    input  logic spi_clk,
    input  logic mosi,
    output logic spi_rise,
    output logic spi_fall,
    output logic mosi_sync
);

    // [0] metastable stage, [1] synchronized, [2] previous synchronized value
    logic [2:0] sclk_q, sclk_d;
    logic [1:0] mosi_q, mosi_d;

    always_comb begin
        sclk_d = {sclk_q[1:0], spi_clk};
        mosi_d = {mosi_q[0], mosi};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= sclk_d;
            mosi_q <= mosi_d;
        end
    end

    assign spi_rise  = sclk_q[1] & ~sclk_q[2];
    assign spi_fall  = ~sclk_q[1] & sclk_q[2];
    assign mosi_sync = mosi_q[1];

endmodule

// File: rtl/spi_chip_responder.sv
// rtl/spi_chip_responder.sv - chip-side SPI responder: frame decode, register file, miso serializer
module spi_chip_responder
    import spi_chip_pkg::*;
#(
    parameter int         N_REGS       = 256,
    parameter int         IDLE_TIMEOUT = 64,
    parameter logic [7:0] RESET_VAL    = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_clk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       wr_strobe,
    output logic       frame_done,
    output logic       frame_error
);

    localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(IDLE_TIMEOUT);

    logic spi_rise, spi_fall, mosi_s;

    spi_edge_sync u_edge_sync (
        .clk       (clk),
        .rstn      (rstn),
        .spi_clk   (spi_clk),
        .mosi      (mosi),
        .spi_rise  (spi_rise),
        .spi_fall  (spi_fall),
        .mosi_sync (mosi_s)
    );

    resp_state_t    state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     rx_sh_q, rx_sh_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [7:0]     count_q, count_d;
    logic [7:0]     tx_sh_q, tx_sh_d;
    logic [2:0]     tx_bit_q, tx_bit_d;
    logic           first_fall_q, first_fall_d;
    logic [TW-1:0]  idle_cnt_q, idle_cnt_d;
    logic           miso_q, miso_d;
    logic           wr_strobe_q, wr_strobe_d;
    logic           frame_done_q, frame_done_d;
    logic           frame_error_q, frame_error_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic [7:0]     mem_q [N_REGS];

    logic [7:0]    rx_byte;
    logic          deser_on;
    logic          byte_done;
    logic          timeout;
    logic [AW-1:0] addr_next;
    logic [7:0]    next_byte;
    logic [7:0]    first_byte;

    assign rx_byte    = {rx_sh_q[6:0], mosi_s};
    assign deser_on   = (state_q != R_DATA) && (state_q != DROP);
    assign byte_done  = deser_on && spi_rise && (bit_cnt_q == 3'd7);
    assign timeout    = (idle_cnt_q == TO_MAX) && (state_q != IDLE) && !(spi_rise || spi_fall);
    assign addr_next  = addr_q + AW'(1);
    assign next_byte  = mem_q[addr_next];
    assign first_byte = mem_q[addr_q];

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_sh_d       = rx_sh_q;
        addr_d        = addr_q;
        count_d       = count_q;
        tx_sh_d       = tx_sh_q;
        tx_bit_d      = tx_bit_q;
        first_fall_d  = first_fall_q;
        miso_d        = miso_q;
        wr_data_d     = wr_data_q;
        wr_strobe_d   = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        if (spi_rise || spi_fall) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != TO_MAX) begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        if (deser_on && spi_rise) begin
            rx_sh_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (spi_rise) state_d = CMD;
            end
            CMD: begin
                if (byte_done) begin
                    if (rx_byte == OP_WRITE) begin
                        state_d = W_ADDR;
                    end else if (rx_byte == OP_READ) begin
                        state_d = R_ADDR;
                    end else begin
                        state_d       = DROP;
                        frame_error_d = 1'b1;
                    end
                end
            end
            W_ADDR: begin
                if (byte_done) begin
                    addr_d  = rx_byte[AW-1:0];
                    state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (byte_done) begin
                    wr_data_d    = rx_byte;
                    wr_strobe_d  = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            R_ADDR: begin
                if (byte_done) begin
                    addr_d  = rx_byte[AW-1:0];
                    state_d = R_COUNT;
                end
            end
            R_COUNT: begin
                if (byte_done) begin
                    if (rx_byte == 8'h00) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        count_d      = rx_byte;
                        tx_sh_d      = first_byte;
                        miso_d       = first_byte[7];
                        tx_bit_d     = 3'd0;
                        first_fall_d = 1'b1;
                        state_d      = R_DATA;
                    end
                end
            end
            R_DATA: begin
                // The trailing fall of the count byte must not shift: MSB is already on miso.
                if (spi_fall && first_fall_q) begin
                    first_fall_d = 1'b0;
                end else if (spi_fall) begin
                    if (tx_bit_q == 3'd7) begin
                        if (count_q == 8'd1) begin
                            frame_done_d = 1'b1;
                            miso_d       = 1'b0;
                            state_d      = IDLE;
                        end else begin
                            count_d  = count_q - 8'd1;
                            addr_d   = addr_next;
                            tx_sh_d  = next_byte;
                            miso_d   = next_byte[7];
                            tx_bit_d = 3'd0;
                        end
                    end else begin
                        tx_sh_d  = {tx_sh_q[6:0], 1'b0};
                        miso_d   = tx_sh_q[6];
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            DROP: begin
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            frame_error_d = (state_q != DROP);
            state_d       = IDLE;
            bit_cnt_d     = 3'd0;
            miso_d        = 1'b0;
            frame_done_d  = 1'b0;
            wr_strobe_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            rx_sh_q       <= 8'h00;
            addr_q        <= '0;
            count_q       <= 8'h00;
            tx_sh_q       <= 8'h00;
            tx_bit_q      <= 3'd0;
            first_fall_q  <= 1'b0;
            idle_cnt_q    <= '0;
            miso_q        <= 1'b0;
            wr_strobe_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            wr_data_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sh_q       <= rx_sh_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            tx_sh_q       <= tx_sh_d;
            tx_bit_q      <= tx_bit_d;
            first_fall_q  <= first_fall_d;
            idle_cnt_q    <= idle_cnt_d;
            miso_q        <= miso_d;
            wr_strobe_q   <= wr_strobe_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            wr_data_q     <= wr_data_d;
        end
    end

    // Commit lands in the cycle wr_strobe is high; addr_q is stable since the frame has ended.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REGS; i++) mem_q[i] <= RESET_VAL;
        end else if (wr_strobe_q) begin
            mem_q[addr_q] <= wr_data_q;
        end
    end

    assign miso        = miso_q;
    assign wr_strobe   = wr_strobe_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign dbg_data    = mem_q[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_spi_chip_responder.sv
// tb/tb_spi_chip_responder.sv - scoreboard bench for spi_chip_responder
module tb_spi_chip_responder;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rstn;
    logic       spi_clk;
    logic       mosi;
    logic       miso;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       wr_strobe;
    logic       frame_done;
    logic       frame_error;

    always #5 clk = ~clk;

    spi_chip_responder dut (
        .clk         (clk),
        .rstn        (rstn),
        .spi_clk     (spi_clk),
        .mosi        (mosi),
        .miso        (miso),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .wr_strobe   (wr_strobe),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    typedef enum logic [1:0] {EV_WR, EV_DONE, EV_ERR, EV_BYTE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] val;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] obs_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mon_b;

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic match(input ev_kind_t k, input logic [7:0] v);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: got %s %02h, required nothing (queue empty)", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BYTE && e.val != v)) begin
                n_bad++;
                $display("FAIL scoreboard: got %s %02h, required %s %02h", k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            while (obs_q.size() > 0) begin
                mon_b = obs_q.pop_front();
                match(EV_BYTE, mon_b);
            end
            if (wr_strobe)   match(EV_WR, 8'h00);
            if (frame_done)  match(EV_DONE, 8'h00);
            if (frame_error) match(EV_ERR, 8'h00);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dbg_check(input string name, input logic [7:0] a, input logic [7:0] req);
        dbg_addr = a;
        #1;
        check(name, dbg_data, req);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            clks(HALF);
            rx = {rx[6:0], miso};
            spi_clk = 1'b1;
            clks(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cmd_byte(input logic [7:0] b);
        logic [7:0] r;
        spi_bits(b, 8, r);
        check("miso_idle", r, 8'h00);
    endtask

    task automatic data_byte();
        logic [7:0] r;
        spi_bits(8'h00, 8, r);
        obs_q.push_back(r);
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] d);
        expect_ev(EV_WR, 8'h00);
        expect_ev(EV_DONE, 8'h00);
        cmd_byte(8'h01);
        cmd_byte(a);
        cmd_byte(d);
        clks(10);
    endtask

    task automatic read_frame(input logic [7:0] a, input logic [7:0] n, input logic [23:0] bytes);
        for (int i = 0; i < int'(n); i++) expect_ev(EV_BYTE, bytes[23 - 8 * i -: 8]);
        expect_ev(EV_DONE, 8'h00);
        cmd_byte(8'h02);
        cmd_byte(a);
        cmd_byte(n);
        for (int i = 0; i < int'(n); i++) data_byte();
        clks(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        rstn     = 1'b0;
        spi_clk  = 1'b0;
        mosi     = 1'b0;
        dbg_addr = 8'h00;
        clks(3);
        check("reset_miso", {7'd0, miso}, 8'h00);
        check("reset_pulses", {5'd0, wr_strobe, frame_done, frame_error}, 8'h00);
        dbg_check("reset_reg00", 8'h00, 8'h00);
        dbg_check("reset_regFF", 8'hFF, 8'h00);
        rstn = 1'b1;
        clks(5);

        // basic write then read back
        write_frame(8'h05, 8'h3C);
        dbg_check("reg05_after_write", 8'h05, 8'h3C);
        read_frame(8'h05, 8'd1, 24'h3C0000);

        // address wrap across 0xFF
        write_frame(8'hFE, 8'h01);
        write_frame(8'hFF, 8'h02);
        write_frame(8'h00, 8'h03);
        read_frame(8'hFE, 8'd3, 24'h010203);

        // bad opcode, then DROP times out silently
        expect_ev(EV_ERR, 8'h00);
        cmd_byte(8'h7F);
        cmd_byte(8'hAA);
        cmd_byte(8'h55);
        clks(100);
        dbg_check("drop_regAA", 8'hAA, 8'h00);
        dbg_check("drop_reg55", 8'h55, 8'h00);
        write_frame(8'h10, 8'h99);
        dbg_check("reg10_after_drop", 8'h10, 8'h99);

        // zero-count read
        read_frame(8'h05, 8'd0, 24'h000000);
        check("miso_after_count0", {7'd0, miso}, 8'h00);

        // timeout mid data byte
        expect_ev(EV_ERR, 8'h00);
        cmd_byte(8'h01);
        cmd_byte(8'h20);
        spi_bits(8'hFF, 4, r);
        clks(100);
        dbg_check("reg20_after_timeout", 8'h20, 8'h00);
        check("miso_after_timeout", {7'd0, miso}, 8'h00);
        write_frame(8'h20, 8'h5A);
        dbg_check("reg20_after_rewrite", 8'h20, 8'h5A);

        // reset during R_DATA
        cmd_byte(8'h02);
        cmd_byte(8'h05);
        cmd_byte(8'h02);
        spi_bits(8'h00, 4, r);
        clks(2);
        rstn = 1'b0;
        clks(2);
        check("rst_midframe_miso", {7'd0, miso}, 8'h00);
        dbg_check("rst_midframe_reg05", 8'h05, 8'h00);
        dbg_check("rst_midframe_reg20", 8'h20, 8'h00);
        rstn = 1'b1;
        clks(5);
        read_frame(8'h05, 8'd1, 24'h000000);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) clks(1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d events still pending, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
